// File: rtl/fetch_unit.sv
// fetch_unit: non-overlapped instruction fetch sequencer with optional immediate word,
// bus timeout fault and flush-driven abort.
module fetch_unit #(
   parameter int LONG_BIT = 15,
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_val,
   output logic        pc_inc,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   input  logic        flush,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] ir,
   output logic [15:0] imm,
   output logic        is_long,
   output logic        fault
);
   typedef enum logic [2:0] {ISSUE0, WAIT0, BUMP0, ISSUE1, WAIT1, BUMP1, VALID, FAULT} state_t;
   state_t      state_q, state_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] imm_q, imm_d;
   logic        is_long_q, is_long_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout;
   assign timeout = ({1'b0, wait_cnt_q} + 17'd1) == 17'(MAX_WAIT);
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = mem_rd_q;
      ir_d       = ir_q;
      imm_d      = imm_q;
      is_long_d  = is_long_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ISSUE0: begin
            mem_addr_d = pc_val;
            mem_rd_d   = 1'b1;
            imm_d      = 16'h0;
            wait_cnt_d = 16'h0;
            state_d    = WAIT0;
         end
         WAIT0, WAIT1: begin
            if (mem_ack) begin
               mem_rd_d = 1'b0;
               if (state_q == WAIT0) begin
                  ir_d      = mem_data;
                  is_long_d = mem_data[LONG_BIT];
                  state_d   = BUMP0;
               end else begin
                  imm_d   = mem_data;
                  state_d = BUMP1;
               end
            end else if (timeout) begin
               mem_rd_d = 1'b0;
               state_d  = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         BUMP0:   state_d = is_long_q ? ISSUE1 : VALID;
         ISSUE1: begin
            mem_addr_d = pc_val;
            mem_rd_d   = 1'b1;
            wait_cnt_d = 16'h0;
            state_d    = WAIT1;
         end
         BUMP1:   state_d = VALID;
         VALID:   state_d = instr_ready ? ISSUE0 : VALID;
         default: state_d = FAULT;
      endcase
      // a redirect discards anything captured this cycle; old ir/imm stay but are invalid
      if (flush) begin
         state_d    = ISSUE0;
         mem_addr_d = mem_addr_q;
         mem_rd_d   = 1'b0;
         ir_d       = ir_q;
         imm_d      = imm_q;
         is_long_d  = is_long_q;
         wait_cnt_d = 16'h0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ISSUE0;
         mem_addr_q <= 16'h0;
         mem_rd_q   <= 1'b0;
         ir_q       <= 16'h0;
         imm_q      <= 16'h0;
         is_long_q  <= 1'b0;
         wait_cnt_q <= 16'h0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         ir_q       <= ir_d;
         imm_q      <= imm_d;
         is_long_q  <= is_long_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end
   assign pc_inc      = (state_q == BUMP0) || (state_q == BUMP1);
   assign instr_valid = state_q == VALID;
   assign fault       = state_q == FAULT;
   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign ir          = ir_q;
   assign imm         = imm_q;
   assign is_long     = is_long_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random-latency memory and PC register around fetch_unit, with a
// program-order scoreboard of expected instructions checked on each handshake.
module tb_fetch_unit;
   localparam int MW = 4;
   logic        clk = 1'b0;
   logic        rst, flush, mem_ack, instr_ready;
   logic [15:0] pc_val, mem_data, flush_pc;
   logic        pc_inc, mem_rd, instr_valid, is_long, fault;
   logic [15:0] mem_addr, ir, imm;
   always #5 clk = ~clk;
   fetch_unit #(.LONG_BIT(15), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .pc_val(pc_val), .pc_inc(pc_inc), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data), .flush(flush),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .ir(ir), .imm(imm),
      .is_long(is_long), .fault(fault)
   );
   typedef struct {logic [15:0] ir; logic [15:0] imm; logic lng;} exp_t;
   exp_t        q[$];
   logic [15:0] mem [65536];
   int          checks = 0, failures = 0;
   bit          mem_en = 1'b1, busy = 1'b0;
   int unsigned max_dly = 0, dly = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // PC register: a redirect write wins over the increment strobe
   always @(posedge clk) begin
      if (flush) pc_val <= flush_pc;
      else if (pc_inc) pc_val <= pc_val + 16'd1;
   end
   initial begin
      mem_ack = 1'b0;
      mem_data = 16'h0;
      forever begin
         step();
         mem_ack = 1'b0;
         mem_data = 16'($urandom);
         if (mem_rd && mem_en) begin
            if (!busy) begin
               busy = 1'b1;
               dly = $urandom_range(max_dly, 0);
            end
            if (dly == 0) begin
               mem_ack = 1'b1;
               mem_data = mem[mem_addr];
               busy = 1'b0;
            end else dly--;
         end else busy = 1'b0;
      end
   end
   initial begin
      bit hold = 1'b0, hs = 1'b0, pfl = 1'b0;
      logic [32:0] prev = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (hold && !pfl) chk("hold_valid", 64'(instr_valid), 64'd1);
         if (hold && instr_valid) chk("hold_stable", 64'({ir, imm, is_long}), 64'(prev));
         if (hs) chk("valid_drop", 64'(instr_valid), 64'd0);
         if (instr_valid) chk("valid_quiet", 64'({mem_rd, pc_inc}), 64'd0);
         if (instr_valid && instr_ready) begin
            if (q.size() == 0) chk("unexpected_instr", 64'(ir), 64'hFFFF_FFFF);
            else begin
               e = q.pop_front();
               chk("ir", 64'(ir), 64'(e.ir));
               chk("imm", 64'(imm), 64'(e.imm));
               chk("is_long", 64'(is_long), 64'(e.lng));
            end
         end
         hold = instr_valid && !instr_ready;
         hs   = instr_valid && instr_ready;
         pfl  = flush || rst;
         prev = {ir, imm, is_long};
      end
   end
   task automatic push_prog(input logic [15:0] start, input int n);
      logic [15:0] p;
      exp_t e;
      p = start;
      for (int i = 0; i < n; i++) begin
         e.ir  = mem[p];
         e.lng = e.ir[15];
         e.imm = e.lng ? mem[p + 16'd1] : 16'h0;
         q.push_back(e);
         p = p + (e.lng ? 16'd2 : 16'd1);
      end
   endtask
   task automatic run_seg(input logic [15:0] start, input int n);
      int t;
      instr_ready = 1'b0;
      repeat ($urandom_range(8, 0)) step();
      flush_pc = start;
      flush = 1'b1;
      push_prog(start, n);
      step();
      flush = 1'b0;
      t = 0;
      forever begin
         if (q.size() == 0 || t > 3000) break;
         instr_ready = $urandom_range(3, 0) != 0;
         step();
         t++;
      end
      instr_ready = 1'b0;
      chk("seg_drain", 64'(q.size()), 64'd0);
      q.delete();
   endtask
   initial begin
      int inc_cnt, inc_at, valid_at, n;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1234;
      mem[16'hFFFF] = 16'h8ABC;
      rst = 1'b1;
      flush = 1'b1;
      flush_pc = 16'h0;
      instr_ready = 1'b0;
      repeat (3) step();
      chk("reset_outs", 64'({pc_inc, mem_rd, instr_valid, fault, is_long}), 64'd0);
      chk("reset_words", 64'({ir, imm, mem_addr}), 64'd0);
      q.push_back('{ir: 16'h1234, imm: 16'h0, lng: 1'b0});
      rst = 1'b0;
      flush = 1'b0;
      instr_ready = 1'b1;
      inc_cnt = 0;
      inc_at = -1;
      valid_at = -1;
      for (int c = 1; c <= 3; c++) begin
         step();
         if (pc_inc) begin
            inc_cnt++;
            inc_at = c;
         end
         if (instr_valid && valid_at < 0) valid_at = c;
         if (c == 1) chk("first_addr", 64'({mem_rd, mem_addr}), 64'h1_0000);
      end
      step();
      instr_ready = 1'b0;
      chk("inc_cycle", 64'(inc_at), 64'd2);
      chk("inc_count", 64'(inc_cnt), 64'd1);
      chk("valid_cycle", 64'(valid_at), 64'd3);
      chk("short_drained", 64'(q.size()), 64'd0);
      q.delete();
      max_dly = 3;
      mem_en = 1'b0;
      flush_pc = 16'h2000;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && !fault; i++) begin
         step();
         if (mem_rd) n++;
      end
      chk("timeout_waits", 64'(n), 64'(MW));
      chk("fault_set", 64'({fault, mem_rd}), 64'b10);
      repeat (3) step();
      chk("fault_sticky", 64'({fault, mem_rd}), 64'b10);
      mem_en = 1'b1;
      flush_pc = 16'h3000;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fault_clear", 64'(fault), 64'd0);
      step();
      chk("restart_addr", 64'({mem_rd, mem_addr}), 64'h1_3000);
      mem_en = 1'b0;
      flush_pc = 16'h5555;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("wait0_rd", 64'({mem_rd, mem_addr}), 64'h1_5555);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_outs", 64'({pc_inc, mem_rd, instr_valid, fault, is_long}), 64'd0);
      chk("rst_mid_words", 64'({ir, imm, mem_addr}), 64'd0);
      mem_en = 1'b1;
      run_seg(16'hFFFF, 3);
      for (int s = 0; s < 40; s++) run_seg(16'($urandom), $urandom_range(6, 1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
